umem_line_responder: RTL and testbench

Memory-side responder for the instruction/data cache line-fill protocol. It accepts one line-sized read or write request from the cache controller, waits a fixed latency to model main-memory delay, then returns a single-cycle `rdy` pulse with read data. It sits below the icache/memory-control state machine in the full processor and owns the backing line store.

---
 rtl/umem_pkg.sv | 15 +
 rtl/umem_line_array.sv | 38 +++
 rtl/umem_line_responder.sv | 140 ++++++++++++++
 tb/tb_umem_line_responder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/umem_pkg.sv
// Shared types and constants for the umem line responder: FSM state encoding,
// line geometry and the latency counter width.
package umem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } umem_state_e;

    localparam int UMEM_WORDS_PER_LINE = 4;
    localparam int UMEM_WORD_W         = 16;
    localparam int UMEM_CNT_W          = 8;

endpackage

// File: rtl/umem_line_array.sv
// Single-port line store: synchronous write, registered read.
// Contents are never reset; only the read register clears on rst.
module umem_line_array #(
    parameter int ADDR_W = 14,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0] i_wdata,
    output logic [LINE_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [LINE_W-1:0] r_mem [0:DEPTH-1];
    logic [LINE_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register only moves on a read, so it holds across writes and idle time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/umem_line_responder.sv
// Memory-side line-fill responder: accepts one read/write, waits LATENCY cycles,
// then pulses rdy. Optional protocol checker enabled by UMEM_PROTOCOL_CHECK_EN.
module umem_line_responder
    import umem_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int LINE_W  = 64,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              re,
    input  logic              we,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rd_data,
    output logic              rdy,
    output logic              busy
`ifdef UMEM_PROTOCOL_CHECK_EN
    ,
    output logic              err
`endif
);

    // Handshake: a request is taken on any rising edge in IDLE with re|we high;
    // re/we are ignored until the rdy cycle has finished and the FSM is IDLE again.
    umem_state_e             r_state;
    umem_state_e             w_next_state;
    logic [UMEM_CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]       r_addr_q;
    logic [LINE_W-1:0]       r_wdata_q;
    logic                    r_is_wr;
    logic                    w_req;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_mem_we;
    logic                    w_mem_re;

    assign w_req    = re | we;
    assign w_accept = (r_state == IDLE) && w_req;
    assign w_done   = (r_state == BUSY) && (r_cnt == '0);
    assign w_mem_we = w_done && r_is_wr;
    assign w_mem_re = w_done && !r_is_wr;

    always_comb begin
        w_next_state = r_state;
        rdy          = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                busy         = 1'b1;
                rdy          = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Simultaneous re/we resolves to a write; counter only decrements while nonzero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_is_wr   <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= UMEM_CNT_W'(LATENCY - 1);
            r_addr_q  <= addr;
            r_wdata_q <= wdata;
            r_is_wr   <= we;
        end else if ((r_state == BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    umem_line_array #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (r_addr_q),
        .i_wdata (r_wdata_q),
        .o_rdata (rd_data)
    );

`ifdef UMEM_PROTOCOL_CHECK_EN
    logic              r_we_d;
    logic              r_re_d;
    logic [ADDR_W-1:0] r_addr_d;
    logic              r_err;
    logic              w_viol;

    assign w_viol = (re && we)
                  || (we && !r_we_d && (r_state != IDLE))
                  || ((r_state == BUSY) && re && r_re_d && (addr != r_addr_d));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we_d   <= 1'b0;
            r_re_d   <= 1'b0;
            r_addr_d <= '0;
            r_err    <= 1'b0;
        end else begin
            r_we_d   <= we;
            r_re_d   <= re;
            r_addr_d <= addr;
            if (w_viol) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_umem_line_responder.sv
// Bench for umem_line_responder: one instance at LATENCY=4, one at LATENCY=1.
module tb_umem_line_responder;
    import umem_pkg::*;

    localparam int AW = 14;
    localparam int LW = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] addr4, addr1;
    logic          re4, we4, re1, we1;
    logic [LW-1:0] wdata4, wdata1, rd_data4, rd_data1;
    logic          rdy4, rdy1, busy4, busy1;
`ifdef UMEM_PROTOCOL_CHECK_EN
    logic          err4, err1;
`endif

    umem_line_responder #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .addr(addr4), .re(re4), .we(we4), .wdata(wdata4),
        .rd_data(rd_data4), .rdy(rdy4), .busy(busy4)
`ifdef UMEM_PROTOCOL_CHECK_EN
        , .err(err4)
`endif
    );

    umem_line_responder #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .addr(addr1), .re(re1), .we(we1), .wdata(wdata1),
        .rd_data(rd_data1), .rdy(rdy1), .busy(busy1)
`ifdef UMEM_PROTOCOL_CHECK_EN
        , .err(err1)
`endif
    );

    int sel = 0;
    wire          s_rdy  = (sel != 0) ? rdy1 : rdy4;
    wire          s_busy = (sel != 0) ? busy1 : busy4;
    wire [LW-1:0] s_rd   = (sel != 0) ? rd_data1 : rd_data4;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] last4 = '0;
    logic [LW-1:0] last1 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
        if (sel != 0) begin
            re1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            re4 = r; we4 = w; addr4 = a; wdata4 = d;
        end
    endtask

    // Call at a negedge with the DUT idle; returns at the negedge after the rdy cycle.
    task automatic access(input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [LW-1:0] d, input logic [LW-1:0] exp);
        int n;
        int lat;
        logic got;
        logic [LW-1:0] e;
        lat = (sel != 0) ? 1 : 4;
        if (!w) exp_q.push_back(exp);
        drive(r, w, a, d);
        @(negedge clk);
        drive(1'b0, 1'b0, AW'($urandom_range(0, 16383)), {$urandom, $urandom});
        check("busy_after_accept", 64'(s_busy), 64'd1);
        n = 1;
        got = s_rdy;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            got = s_rdy;
        end
        check("rdy_latency", 64'(n), 64'(lat + 1));
        if (got) begin
            if (!w) begin
                e = exp_q.pop_front();
                check("rd_data_on_rdy", s_rd, e);
                if (sel != 0) last1 = e; else last4 = e;
            end else begin
                check("rd_data_hold_on_write", s_rd, (sel != 0) ? last1 : last4);
            end
            @(negedge clk);
            check("rdy_single_cycle", 64'(s_rdy), 64'd0);
            check("idle_after_resp", 64'(s_busy), 64'd0);
        end else if (!w && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [LW-1:0] d;
        logic [LW-1:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int pulses;
        int first_at;
        int hits;
        logic [AW-1:0] ra;
        logic [LW-1:0] rv;

        tbl[0] = '{1'b0, 1'b1, 14'h0005, 64'h1111_2222_3333_4444, 64'h0};
        tbl[1] = '{1'b1, 1'b0, 14'h0005, 64'h0,                   64'h1111_2222_3333_4444};
        tbl[2] = '{1'b0, 1'b1, 14'h3FFF, 64'h0123_4567_89AB_CDEF, 64'h0};
        tbl[3] = '{1'b0, 1'b1, 14'h0000, 64'hFFFF_0000_FFFF_0000, 64'h0};
        tbl[4] = '{1'b1, 1'b0, 14'h0000, 64'h0,                   64'hFFFF_0000_FFFF_0000};
        tbl[5] = '{1'b1, 1'b0, 14'h3FFF, 64'h0,                   64'h0123_4567_89AB_CDEF};
        tbl[6] = '{1'b1, 1'b1, 14'h0010, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0};
        tbl[7] = '{1'b1, 1'b0, 14'h0010, 64'h0,                   64'hAAAA_BBBB_CCCC_DDDD};
        tbl[8] = '{1'b0, 1'b1, 14'h0020, 64'h5555_6666_7777_8888, 64'h0};
        tbl[9] = '{1'b1, 1'b0, 14'h0020, 64'h0,                   64'h5555_6666_7777_8888};

        re4 = 0; we4 = 0; addr4 = '0; wdata4 = '0;
        re1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("reset_rdy", 64'(rdy4), 64'd0);
        check("reset_busy", 64'(busy4), 64'd0);
        check("reset_rd_data", rd_data4, 64'd0);
        check("reset_cnt", 64'(dut4.r_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven accesses at LATENCY=4
        sel = 0;
        for (int i = 0; i < 10; i++) begin
            access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp);
`ifdef UMEM_PROTOCOL_CHECK_EN
            if (i == 5) check("err_clean", 64'(err4), 64'd0);
            if (i == 6) check("err_re_we", 64'(err4), 64'd1);
`endif
        end

        // Random write/read pairs
        for (int i = 0; i < 4; i++) begin
            ra = AW'($urandom_range(64, 16000));
            rv = {$urandom, $urandom};
            access(1'b0, 1'b1, ra, rv, 64'h0);
            access(1'b1, 1'b0, ra, 64'h0, rv);
        end

        // re held high for 12 edges at 0x3FFF: two accesses
        exp_q.push_back(64'h0123_4567_89AB_CDEF);
        exp_q.push_back(64'h0123_4567_89AB_CDEF);
        drive(1'b1, 1'b0, 14'h3FFF, 64'h0);
        pulses = 0;
        first_at = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 12) drive(1'b0, 1'b0, 14'h0, 64'h0);
            if (rdy4) begin
                pulses++;
                if (pulses == 1) first_at = i;
                if (exp_q.size() > 0) check("held_re_data", rd_data4, exp_q.pop_front());
            end
        end
        check("held_re_pulses", 64'(pulses), 64'd2);
        check("held_re_first_latency", 64'(first_at), 64'd5);
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        last4 = 64'h0123_4567_89AB_CDEF;

        // Reset two cycles into a write
        drive(1'b0, 1'b1, 14'h0020, 64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        drive(1'b0, 1'b0, 14'h0, 64'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_rdy", 64'(rdy4), 64'd0);
        check("midrst_busy", 64'(busy4), 64'd0);
        check("midrst_rd_data", rd_data4, 64'd0);
        check("midrst_state", 64'(dut4.r_state), 64'(IDLE));
`ifdef UMEM_PROTOCOL_CHECK_EN
        check("midrst_err", 64'(err4), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        last4 = '0;
        last1 = '0;
        hits = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rdy4) hits++;
        end
        check("midrst_no_rdy", 64'(hits), 64'd0);
        access(1'b1, 1'b0, 14'h0020, 64'h0, 64'h5555_6666_7777_8888);

        // LATENCY=1 instance
        sel = 1;
        access(1'b0, 1'b1, 14'h0001, 64'h0101_0202_0303_0404, 64'h0);
        access(1'b0, 1'b1, 14'h0002, 64'hF0F0_E1E1_D2D2_C3C3, 64'h0);
        access(1'b1, 1'b0, 14'h0001, 64'h0, 64'h0101_0202_0303_0404);
        access(1'b1, 1'b0, 14'h0002, 64'h0, 64'hF0F0_E1E1_D2D2_C3C3);

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
